// File: rtl/sfifo_16i_64o_512.sv
// Single-clock width-upsizing FIFO: packs 16-bit writes little-endian into 64-bit rows,
// 512 x 16 storage seen as 128 x 64 on the read side.
// Latency: a row becomes readable on the edge that writes its fourth word.
// rd_data is registered, so it is valid one cycle after an accepted rd_en.
// Backpressure: wr_en is ignored while wr_full. rd_en is ignored while rd_empty (fewer than 4 words).
// Ports:
//   clk, rst (async active-high)
//   write side: wr_data, wr_en, wr_full, wr_water_level, almost_full
//   read side:  rd_data, rd_en, rd_empty, rd_water_level, almost_empty
module sfifo_16i_64o_512 #(
    parameter int WR_DEPTH_WIDTH   = 9,
    parameter int WR_DATA_WIDTH    = 16,
    parameter int RD_DEPTH_WIDTH   = 7,
    parameter int RD_DATA_WIDTH    = 64,
    parameter int ALMOST_FULL_NUM  = 508,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    input  logic                      wr_en,
    output logic                      wr_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    output logic                      almost_full,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    input  logic                      rd_en,
    output logic                      rd_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    output logic                      almost_empty
);

    localparam int ROWS  = 1 << RD_DEPTH_WIDTH;
    localparam int LANES = RD_DATA_WIDTH / WR_DATA_WIDTH;

    localparam logic [WR_DEPTH_WIDTH:0] FULL_CNT = (WR_DEPTH_WIDTH + 1)'(1 << WR_DEPTH_WIDTH);
    localparam logic [WR_DEPTH_WIDTH:0] AF_CNT   = (WR_DEPTH_WIDTH + 1)'(ALMOST_FULL_NUM);
    localparam logic [RD_DEPTH_WIDTH:0] AE_CNT   = (RD_DEPTH_WIDTH + 1)'(ALMOST_EMPTY_NUM);

    // Pointers carry one extra wrap bit above the address so full and empty differ.
    logic [WR_DEPTH_WIDTH:0]     wr_ptr_q, wr_ptr_d;
    logic [RD_DEPTH_WIDTH:0]     rd_ptr_q, rd_ptr_d;
    logic [RD_DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
    logic [RD_DATA_WIDTH-1:0]    mem [ROWS];

    logic [WR_DEPTH_WIDTH:0]     count;
    logic [RD_DEPTH_WIDTH-1:0]   wr_row;
    logic [1:0]                  wr_lane;
    logic                        wr_accept;
    logic                        rd_accept;

    // Count in 16-bit words: the read pointer counts rows, so scale it by 4.
    assign count   = wr_ptr_q - {rd_ptr_q, 2'b00};
    assign wr_row  = wr_ptr_q[WR_DEPTH_WIDTH-1:2];
    assign wr_lane = wr_ptr_q[1:0];

    assign wr_full        = (count == FULL_CNT);
    assign wr_water_level = count;
    assign almost_full    = (count >= AF_CNT);
    // Only complete rows are visible to the reader; a partial row floors out.
    assign rd_water_level = count[WR_DEPTH_WIDTH:2];
    assign rd_empty       = (count[WR_DEPTH_WIDTH:2] == '0);
    assign almost_empty   = (rd_water_level <= AE_CNT);
    assign rd_data        = rd_data_q;

    // Legality is judged on pre-edge flags. A row still being filled keeps rd_empty high,
    // so a read can never target the row a same-cycle write is completing.
    assign wr_accept = wr_en & ~wr_full;
    assign rd_accept = rd_en & ~rd_empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem[rd_ptr_q[RD_DEPTH_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage has no reset: after reset the pointers alone mark it empty.
    // The low pointer bits pick the lane, so the first word of a row lands in bits [15:0].
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (wr_accept && (wr_lane == 2'(l))) begin
                mem[wr_row][l*WR_DATA_WIDTH +: WR_DATA_WIDTH] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_sfifo_16i_64o_512.sv
module tb_sfifo_16i_64o_512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        wr_full;
    logic [9:0]  wr_water_level;
    logic        almost_full;
    logic [63:0] rd_data;
    logic        rd_en = 1'b0;
    logic        rd_empty;
    logic [7:0]  rd_water_level;
    logic        almost_empty;

    sfifo_16i_64o_512 dut (
        .clk            (clk),
        .rst            (rst),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .wr_water_level (wr_water_level),
        .almost_full    (almost_full),
        .rd_data        (rd_data),
        .rd_en          (rd_en),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .almost_empty   (almost_empty)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] model_q[$];     // reference contents, oldest word first
    logic [63:0] exp_q[$];       // expected rd_data for each accepted read
    bit          rd_acc = 1'b0;  // reference says the read at the next edge is accepted
    logic [63:0] last_rd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_flags();
        int n;
        n = model_q.size();
        chk("wr_water_level", 64'(wr_water_level), 64'(n));
        chk("rd_water_level", 64'(rd_water_level), 64'(n / 4));
        chk("wr_full",        64'(wr_full),        64'(n == 512));
        chk("rd_empty",       64'(rd_empty),       64'(n < 4));
        chk("almost_full",    64'(almost_full),    64'(n >= 508));
        chk("almost_empty",   64'(almost_empty),   64'((n / 4) <= 4));
    endtask

    task automatic check_reset_outputs();
        chk("rst_rd_data",        rd_data,               64'h0);
        chk("rst_wr_water_level", 64'(wr_water_level),   64'h0);
        chk("rst_rd_water_level", 64'(rd_water_level),   64'h0);
        chk("rst_wr_full",        64'(wr_full),          64'h0);
        chk("rst_almost_full",    64'(almost_full),      64'h0);
        chk("rst_rd_empty",       64'(rd_empty),         64'h1);
        chk("rst_almost_empty",   64'(almost_empty),     64'h1);
    endtask

    // Called at a negedge: check state, drive inputs, update the reference, run one edge.
    task automatic step(input bit wr, input logic [15:0] d, input bit rd);
        int          n;
        logic [63:0] row;
        check_flags();
        n       = model_q.size();
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        rd_acc  = rd && (n >= 4);
        if (rd_acc) begin
            row = '0;
            for (int i = 0; i < 4; i++) row[16*i +: 16] = model_q.pop_front();
            exp_q.push_back(row);
        end
        if (wr && (n < 512)) model_q.push_back(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserts reset in the middle of a low phase and checks the outputs before any edge.
    task automatic do_reset();
        rd_acc = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        model_q.delete();
        exp_q.delete();
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: after each edge, compare rd_data with the next expected row or its held value.
    initial begin
        bit fire;
        bit was_rst;
        forever begin
            @(posedge clk);
            fire    = rd_acc;
            was_rst = rst;
            #1;
            if (was_rst || rst) begin
                last_rd = '0;
            end else if (fire) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_scoreboard: read accepted with no expected row at %0t", $time);
                end else begin
                    last_rd = exp_q.pop_front();
                    chk("rd_data", rd_data, last_rd);
                end
            end else begin
                chk("rd_data_hold", rd_data, last_rd);
            end
        end
    end

    initial begin
        int written;
        int guard;
        bit wr;
        bit rd;

        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Four words complete one row; the first word written is the low lane.
        for (int i = 0; i < 4; i++) step(1'b1, 16'hFFFF - 16'(i), 1'b0);
        chk("lvl4_wr", 64'(wr_water_level), 64'd4);
        chk("lvl4_rd", 64'(rd_water_level), 64'd1);
        step(1'b0, '0, 1'b1);
        chk("first_row", rd_data, 64'hFFFC_FFFD_FFFE_FFFF);

        // Fill to full, one extra write is dropped, then drain.
        for (int i = 0; i < 512; i++) step(1'b1, 16'hFFFF - 16'(i), 1'b0);
        chk("full_flag", 64'(wr_full), 64'd1);
        step(1'b1, 16'h1234, 1'b0);
        chk("full_level_hold", 64'(wr_water_level), 64'd512);
        for (int i = 0; i < 128; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("drained_empty", 64'(rd_empty), 64'd1);

        // Partial row: three words are not readable and rd_data stays at its reset value.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 16'hA000 + 16'(i), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("partial_rd_data", rd_data, 64'h0);
        chk("partial_rd_level", 64'(rd_water_level), 64'd0);

        // Simultaneous write and read at level 8: net -3, read returns the oldest row.
        for (int i = 3; i < 8; i++) step(1'b1, 16'hA000 + 16'(i), 1'b0);
        step(1'b1, 16'hB000, 1'b1);
        chk("simul_level", 64'(wr_water_level), 64'd5);
        chk("simul_row", rd_data, 64'hA003_A002_A001_A000);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1);

        // Random stream, pointers wrap several times.
        written = 0;
        guard   = 0;
        while (written < 2000 && guard < 20000) begin
            wr = ($urandom_range(0, 99) < 60);
            rd = ($urandom_range(0, 99) < ((written < 1000) ? 8 : 20));
            if (wr && model_q.size() < 512) written++;
            step(wr, 16'($urandom), rd);
            guard++;
        end
        chk("stream_completed", 64'(written), 64'd2000);
        while (model_q.size() >= 4) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Asynchronous reset at level 100, then a clean restart.
        do_reset();
        for (int i = 0; i < 100; i++) step(1'b1, 16'($urandom), 1'b0);
        chk("pre_rst_level", 64'(wr_water_level), 64'd100);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 16'h00FF - 16'(i), 1'b0);
        step(1'b0, '0, 1'b1);
        chk("post_rst_row", rd_data, 64'h00FC_00FD_00FE_00FF);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
